// File: rtl/irq_capture_4.sv
// Four-channel request capture: edge/level detection into a pending register,
// masking, and a registered highest-priority index over a valid/ready handshake.
module irq_capture_4 #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] mask,
    input  logic [3:0] clr,
    output logic [3:0] pending,
    output logic       irq_valid,
    output logic [1:0] irq_id,
    input  logic       irq_ready
);

    logic [3:0] req_q;
    logic [3:0] set;
    logic [3:0] ack;
    logic [3:0] elig;
    logic [3:0] pending_nxt;
    logic [1:0] elig_id;
    logic       accept;
    logic       out_load;

    // NOTE: req_q deliberately has no reset branch; it must keep tracking req
    // during reset so a request held high through reset does not look like an edge.
    always_ff @(posedge clk) begin
        req_q <= req;
    end

    assign set = EDGE_MODE ? (req & ~req_q) : req;

    assign accept   = irq_valid & irq_ready;
    assign ack      = accept ? (4'b0001 << irq_id) : 4'b0000;
    assign out_load = ~irq_valid | accept;

    // clr dominates set, set dominates the acknowledge of the presented channel.
    assign pending_nxt = ((pending & ~ack) | set) & ~clr;

    // The channel being acknowledged this cycle is excluded so it is never
    // presented twice from a single pending event.
    assign elig = pending & mask & ~ack;

    // NOTE: elig_id gets its default before the loop; without it the
    // elig == 0 path would leave it unassigned and infer a latch.
    always_comb begin
        elig_id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (elig[i]) begin
                elig_id = 2'(i);
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 4'b0000;
            irq_valid <= 1'b0;
            irq_id    <= 2'd0;
        end else begin
            pending <= pending_nxt;
            // A presented index is held until accepted, whatever mask/clr/req do.
            if (out_load) begin
                irq_valid <= |elig;
                irq_id    <= elig_id;
            end
        end
    end

endmodule
